// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path.
//   KEY_* : bit index of each board key in the NUM_KEYS-wide key buses
//   DEF_* : default cycle constants for a 50 MHz i_clk
//   key_evt_t : per-channel view {level, press, long}
package key_pkg;

  localparam int KEY_REC_PLAY = 0;
  localparam int KEY_PAUSE    = 1;
  localparam int KEY_STOP     = 2;

  localparam int DEF_NUM_KEYS        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
  localparam int DEF_LONG_CYCLES     = 50_000_000;  // 1 s

  typedef struct packed {
    logic level;  // debounced level, 1 = pressed
    logic press;  // accepted press edge, about to appear on level
    logic long;   // hold counter reaching LONG_CYCLES this edge
  } key_evt_t;

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-FF synchronizer, debounce filter and hold counter.
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_key_n : raw button, active-low, asynchronous to i_clk
//   o_evt   : level = registered debounced level;
//             press/long = strobes that take effect at the next edge
//             (registered and mask-gated by the parent)
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_key_n,
  output key_evt_t o_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pressed;

  always_comb begin
    sync1_d  = i_key_n;
    sync2_d  = sync1_q;
    pressed  = ~sync2_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    hold_d   = hold_q;

    // Any disagreement must persist for DEBOUNCE_CYCLES consecutive cycles;
    // a single agreeing cycle restarts the count.
    if (pressed == stable_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_LAST) begin
      stable_d = pressed;
      deb_d    = '0;
    end else begin
      deb_d = deb_q + 1'b1;
    end

    // Cleared on the same edge the level falls; counting starts the cycle
    // after the level rises, so hold == n means n cycles of visible press.
    if (!stable_d) begin
      hold_d = '0;
    end else if (stable_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end

    o_evt.level = stable_q;
    o_evt.press = stable_d & ~stable_q;
    // Saturation makes this true on exactly one edge per press.
    o_evt.long  = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      deb_q    <= '0;
      hold_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Turns the raw active-low DE2 push-buttons into clean one-cycle key strobes
// for the recorder/player control FSM.
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_key_n : raw buttons [NUM_KEYS], active-low, asynchronous
//   i_mask  : 1 = drop o_press/o_long (o_level keeps tracking)
//   o_level : debounced level per key, 1 = pressed
//   o_press : one-cycle pulse in the cycle o_level rises
//   o_long  : one-cycle pulse once a press has been held LONG_CYCLES
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_key_n,
  input  logic                i_mask,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_long
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_param
    $error("key_conditioner: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  key_evt_t            evt [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] long_q, long_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_key_n(i_key_n[k]),
      .o_evt  (evt[k])
    );
    assign o_level[k] = evt[k].level;
  end

  // The mask is applied on the edge that loads the pulse, so a masked
  // event is simply dropped rather than held for later.
  always_comb begin
    press_d = '0;
    long_d  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      press_d[k] = evt[k].press & ~i_mask;
      long_d[k]  = evt[k].long  & ~i_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_q <= '0;
      long_q  <= '0;
    end else begin
      press_q <= press_d;
      long_q  <= long_d;
    end
  end

  assign o_press = press_q;
  assign o_long  = long_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
// Stimulus pushes expected pulses (ev_q) and expected output snapshots
// (st_q) tagged with the cycle they must appear in; the monitor checks them.
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int DEB = 4;
  localparam int LNG = 16;
  localparam int LAT = 2 + DEB;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_n;
  logic          mask;
  logic [NK-1:0] o_level, o_press, o_long;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_key_n(key_n),
    .i_mask (mask),
    .o_level(o_level),
    .o_press(o_press),
    .o_long (o_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] lng;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] lng;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  done   = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [NK-1:0] p, input logic [NK-1:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.lng = l;
    ev_q.push_back(e);
  endtask

  task automatic push_st(input int c, input logic [NK-1:0] lv, input logic [NK-1:0] p,
                         input logic [NK-1:0] l);
    st_t s;
    s.cyc = c; s.level = lv; s.press = p; s.lng = l;
    st_q.push_back(s);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!done && cyc < 3000) begin
      while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
        st_t s;
        s = st_q.pop_front();
        n_cmp++; n_fail++;
        $display("FAIL state_skipped: expected check at cycle %0d, now %0d", s.cyc, cyc);
      end
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        st_t s;
        s = st_q.pop_front();
        n_cmp++;
        if (o_level !== s.level || o_press !== s.press || o_long !== s.lng) begin
          n_fail++;
          $display("FAIL state@%0d: got level=%b press=%b long=%b, want level=%b press=%b long=%b",
                   cyc, o_level, o_press, o_long, s.level, s.press, s.lng);
        end
      end
      if ((o_press | o_long) !== '0) begin
        n_cmp++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected@%0d: got press=%b long=%b, want none",
                   cyc, o_press, o_long);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.cyc != cyc || o_press !== e.press || o_long !== e.lng) begin
            n_fail++;
            $display("FAIL pulse@%0d: got press=%b long=%b, want press=%b long=%b at cycle %0d",
                     cyc, o_press, o_long, e.press, e.lng, e.cyc);
          end
        end
      end
    end else begin
      if (!done) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: cycle %0d reached, want stimulus done", cyc);
      end
      while (ev_q.size() > 0) begin
        ev_t e;
        e = ev_q.pop_front();
        n_cmp++; n_fail++;
        $display("FAIL pulse_missing: got nothing, want press=%b long=%b at cycle %0d",
                 e.press, e.lng, e.cyc);
      end
      while (st_q.size() > 0) begin
        st_t s;
        s = st_q.pop_front();
        n_cmp++; n_fail++;
        $display("FAIL state_missing: got no check, want one at cycle %0d", s.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  int t;

  initial begin
    rst = 1'b1; key_n = '0; mask = 1'b0;

    // Reset with every key pressed: outputs held at 0
    step(2);
    push_st(cyc, 3'b000, 3'b000, 3'b000);
    push_st(cyc + 1, 3'b000, 3'b000, 3'b000);
    step(1);
    key_n = 3'b110;
    step(1);

    // Release with key 0 held
    rst = 1'b0; t = cyc;
    push_st(t + LAT - 1, 3'b000, 3'b000, 3'b000);
    push_st(t + LAT,     3'b001, 3'b001, 3'b000);
    push_ev(t + LAT, 3'b001, 3'b000);
    step(4);
    key_n[0] = 1'b1; t = cyc;
    push_st(t + LAT - 1, 3'b001, 3'b000, 3'b000);
    push_st(t + LAT,     3'b000, 3'b000, 3'b000);
    step(20);

    // Bounce on key 1: 2-cycle glitches never reach the level
    t = cyc;
    push_st(t + 19, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 10; i++) begin
      key_n[1] = i[0];
      step(2);
    end
    key_n[1] = 1'b0; t = cyc;
    push_st(t + LAT, 3'b010, 3'b010, 3'b000);
    push_ev(t + LAT, 3'b010, 3'b000);
    step(10);
    key_n[1] = 1'b1; t = cyc;
    push_st(t + LAT, 3'b000, 3'b000, 3'b000);
    step(20);

    // Long press on key 2, held 30 cycles
    key_n[2] = 1'b0; t = cyc;
    push_st(t + LAT, 3'b100, 3'b100, 3'b000);
    push_ev(t + LAT, 3'b100, 3'b000);
    push_st(t + LAT + LNG, 3'b100, 3'b000, 3'b100);
    push_ev(t + LAT + LNG, 3'b000, 3'b100);
    step(30);
    key_n[2] = 1'b1; t = cyc;
    push_st(t + LAT - 1, 3'b100, 3'b000, 3'b000);
    push_st(t + LAT,     3'b000, 3'b000, 3'b000);
    step(20);

    // Masked press is lost; long still fires once unmasked
    mask = 1'b1; key_n[0] = 1'b0; t = cyc;
    push_st(t + LAT, 3'b001, 3'b000, 3'b000);
    push_ev(t + LAT + LNG, 3'b000, 3'b001);
    step(LAT + 1);
    mask = 1'b0;
    step(18);
    key_n[0] = 1'b1;
    step(20);

    // Keys 0 and 2 together
    key_n = 3'b010; t = cyc;
    push_st(t + LAT, 3'b101, 3'b101, 3'b000);
    push_ev(t + LAT, 3'b101, 3'b000);
    step(10);
    key_n = 3'b111;
    step(20);

    // Reset at hold count 10 with key 0 still held
    key_n[0] = 1'b0; t = cyc;
    push_ev(t + LAT, 3'b001, 3'b000);
    step(LAT + 10);
    rst = 1'b1;
    push_st(cyc, 3'b000, 3'b000, 3'b000);
    step(1);
    rst = 1'b0; t = cyc;
    push_st(t + LAT - 1, 3'b000, 3'b000, 3'b000);
    push_st(t + LAT, 3'b001, 3'b001, 3'b000);
    push_ev(t + LAT, 3'b001, 3'b000);
    push_ev(t + LAT + LNG, 3'b000, 3'b001);
    step(30);
    key_n[0] = 1'b1;
    step(20);

    done = 1'b1;
  end

endmodule
